stim_reset_sequencer: RTL
=========================

// Module: stim_reset_sequencer
// PURPOSE
//  Synthesizable sequencer for DUT bring-up: produces divide-by-2 and divide-by-4 clock enables,
//  a timed synchronous reset pulse, a stepped 4-bit stimulus pattern (0000 -> 0011 -> 1100),
//  and a run-window timeout that ends with a done pulse. Sits between the bench/top-level
//  start control and the DUT's rst/data inputs; replaces free-running delay-based sequencing.
// PARAMETERS
//  RST_CYCLES   3   cycles rst_out held high after leaving IDLE (>=1)
//  STEP_CYCLES  2   cycles each stimulus value is held (>=1)
//  TIMEOUT      20  total busy cycles per run; elaboration error unless TIMEOUT >= RST_CYCLES+3*STEP_CYCLES+1
//  CW           8   cycle_cnt width; elaboration error unless TIMEOUT <= 2**CW
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  start      in   1     request a run; sampled only in IDLE
//  abort      in   1     cancel run; sampled in RESET/STIM/RUN and IDLE
//  en_div2    out  1     clock enable, high every 2nd cycle
//  en_div4    out  1     clock enable, high every 4th cycle
//  rst_out    out  1     active-high synchronous reset to DUT
//  temp       out  4     stimulus value to DUT
//  busy       out  1     high in RESET, STIM, RUN
//  done       out  1     one-cycle pulse at normal completion
//  cycle_cnt  out  CW    cycles elapsed in current/last run
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, div_cnt=0, cycle_cnt=0, all outputs 0, temp=4'b0000.
//  - All outputs registered, or decoded from registered state only; no comb path from inputs.
//  - Divider: 2-bit div_cnt increments every cycle from 0 after reset release, wraps 3->0.
//    en_div2 = (div_cnt[0]==1); en_div4 = (div_cnt==3). Free-running, independent of FSM.
//  - FSM states: IDLE, RESET, STIM, RUN, DONE.
//  - IDLE: temp=0000, cycle_cnt holds. start=1 & abort=0 -> RESET; start & abort same cycle -> stay IDLE.
//  - RESET: entered with cycle_cnt=0; rst_out=1 for RST_CYCLES cycles, then STIM.
//  - STIM: rst_out=0; temp=0000 for STEP_CYCLES, 0011 for STEP_CYCLES, 1100 for STEP_CYCLES, then RUN.
//  - RUN: temp holds 1100; when cycle_cnt==TIMEOUT-1 -> DONE.
//  - cycle_cnt increments by 1 every busy cycle (0..TIMEOUT-1); holds in DONE and IDLE.
//  - DONE: exactly one cycle; done=1, busy=0, temp=1100, cycle_cnt=TIMEOUT-1; then IDLE.
//  - abort=1 in RESET/STIM/RUN -> IDLE next cycle: rst_out=0, temp=0000, done never pulses,
//    cycle_cnt holds value at abort.
//  - start while busy or in DONE: ignored (no queueing).
//  - Async reset mid-run: immediate return to reset values; no done pulse.
//  - Cycle-exact run (defaults, start sampled at edge 0): rst_out=1 cycles 1-3; temp 0000 cycles 4-5,
//    0011 cycles 6-7, 1100 cycles 8-20; busy cycles 1-20; done cycle 21; IDLE from cycle 22.
// TESTING
//  1. Reset release, no start, 8 cycles -> en_div2 on cycles 1,3,5,7; en_div4 on 3,7; busy=0, temp=0000.
//  2. Defaults, start pulse at edge 0 -> rst_out cycles 1-3, temp 0000/0011/1100 per timeline above,
//     done single pulse cycle 21, cycle_cnt=19 afterwards.
//  3. abort at cycle 6 (STIM) -> cycle 7 IDLE, temp=0000, rst_out=0, cycle_cnt=5, done never high.
//  4. start held high through run -> exactly one run, then second run begins immediately after
//     DONE->IDLE (RESET entered cycle 23); no overlap, done pulses once per run.
//  5. start and abort same cycle in IDLE -> stays IDLE, busy=0.
//  6. rst asserted at cycle 10 (RUN) -> outputs to reset values asynchronously; fresh start
//     after release reproduces timeline of scenario 2 from cycle_cnt=0.

Source files
------------

// File: rtl/stim_reset_sequencer_if.sv
// Bring-up control bundle between the start/abort controller and the
// stim_reset_sequencer.
//   master : drives start/abort, observes the sequencer outputs (bench or top level)
//   slave  : the sequencer itself
//   start, abort        run request / cancel
//   en_div2, en_div4    free-running clock enables
//   rst_out             active-high synchronous reset for the DUT
//   temp[3:0]           stimulus value for the DUT
//   busy, done          run in progress / one-cycle completion pulse
//   cycle_cnt[CW-1:0]   busy cycles elapsed in the current or last run
interface stim_reset_sequencer_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          en_div2;
  logic          en_div4;
  logic          rst_out;
  logic [3:0]    temp;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output start, abort,
    input  en_div2, en_div4, rst_out, temp, busy, done, cycle_cnt
  );

  modport slave (
    input  start, abort,
    output en_div2, en_div4, rst_out, temp, busy, done, cycle_cnt
  );
endinterface

// File: rtl/stim_reset_sequencer.sv
// Sequencer for DUT bring-up. After a start request it holds the DUT in reset
// for RST_CYCLES cycles, steps the stimulus 0000 -> 0011 -> 1100 (STEP_CYCLES
// each), then lets the DUT run until TIMEOUT busy cycles have elapsed and
// pulses done. A free-running 2-bit divider supplies /2 and /4 clock enables.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stim_reset_sequencer_if slave modport (start/abort in, everything else out)
// Every output is decoded from registered state only.
module stim_reset_sequencer #(
  parameter int RST_CYCLES  = 3,
  parameter int STEP_CYCLES = 2,
  parameter int TIMEOUT     = 20,
  parameter int CW          = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stim_reset_sequencer_if.slave   bus
);

  localparam int StimLen  = 3 * STEP_CYCLES;
  localparam int PhaseMax = (RST_CYCLES > StimLen) ? RST_CYCLES : StimLen;
  localparam int PW       = $clog2(PhaseMax + 1);

  // Reject parameter sets that would leave RUN with no cycles or overflow cycle_cnt.
  if (RST_CYCLES < 1) begin : gBadRst
    $error("RST_CYCLES must be at least 1");
  end
  if (STEP_CYCLES < 1) begin : gBadStep
    $error("STEP_CYCLES must be at least 1");
  end
  if (TIMEOUT < RST_CYCLES + 3 * STEP_CYCLES + 1) begin : gBadTimeout
    $error("TIMEOUT too short for reset and stimulus phases");
  end
  if (TIMEOUT > (1 << CW)) begin : gBadWidth
    $error("cycle_cnt width CW too small for TIMEOUT");
  end

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    STIM,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cycleCnt_q, cycleCnt_d;
  logic [1:0]    divCnt_q;
  logic [3:0]    tempDec;

  // Free-running divider; it never looks at the FSM so the enables keep their
  // phase across runs and aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + 2'd1;
    end
  end

  // State, in-phase position and the busy-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      cycleCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  // Next-state logic. cycle_cnt advances only when the next cycle is still
  // busy, so it stops at TIMEOUT-1 on completion and keeps its value on abort.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cycleCnt_d = cycleCnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = RESET;
          phase_d    = '0;
          cycleCnt_d = '0;
        end
      end
      RESET: begin
        if (bus.abort) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          cycleCnt_d = cycleCnt_q + CW'(1);
          if (phase_q == PW'(RST_CYCLES - 1)) begin
            state_d = STIM;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      STIM: begin
        if (bus.abort) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          cycleCnt_d = cycleCnt_q + CW'(1);
          if (phase_q == PW'(StimLen - 1)) begin
            state_d = RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cycleCnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
        end else begin
          cycleCnt_d = cycleCnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Stimulus decode: the STIM phase position selects one of three steps;
  // RUN and DONE keep the last step on the DUT inputs.
  always_comb begin
    tempDec = 4'b0000;
    unique case (state_q)
      STIM: begin
        if (phase_q < PW'(STEP_CYCLES)) begin
          tempDec = 4'b0000;
        end else if (phase_q < PW'(2 * STEP_CYCLES)) begin
          tempDec = 4'b0011;
        end else begin
          tempDec = 4'b1100;
        end
      end
      RUN, DONE: tempDec = 4'b1100;
      default:   tempDec = 4'b0000;
    endcase
  end

  assign bus.en_div2   = divCnt_q[0];
  assign bus.en_div4   = &divCnt_q;
  assign bus.rst_out   = (state_q == RESET);
  assign bus.busy      = (state_q == RESET) || (state_q == STIM) || (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.temp      = tempDec;
  assign bus.cycle_cnt = cycleCnt_q;

endmodule
